bank_scheduler: RTL and testbench
=================================

# bank_scheduler

Sequencer that walks the battery-bank digit ROM, streams each bank's digits into the max-joltage engine one digit per cycle, waits for that bank's result, and accumulates the total score. Sits inside `top` between the input ROM and the per-bank compute engine. Drives the `score` value that `top` exports. Runs autonomously from reset release to completion; no software start.

## Interface

- NUM_BANKS, 200, number of banks (lines) in the ROM
- BANK_LEN, 100, digits per bank; ROM is dense, bank b at addresses b*BANK_LEN .. b*BANK_LEN+BANK_LEN-1
- ADDR_W, 15, ROM address width; must satisfy 2^ADDR_W >= NUM_BANKS*BANK_LEN
- RESULT_W, 8, engine result width (max 99)
- SCORE_W, 32, accumulator width

Ports:

- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- rom_addr  out  ADDR_W  ROM read address; synchronous ROM, data valid the cycle after
- rom_data  in  4  digit 0-9 for the address presented the previous cycle
- eng_start  out  1  one-cycle pulse, coincident with the first digit of each bank
- eng_valid  out  1  eng_digit valid
- eng_digit  out  4  digit to engine
- eng_last  out  1  marks the final digit of a bank (index BANK_LEN-1)
- eng_ready  in  1  engine accepts a digit when eng_valid && eng_ready
- eng_result  in  RESULT_W  bank result
- eng_result_valid  in  1  one-cycle pulse with eng_result
- score  out  SCORE_W  running sum of accepted results
- bank_idx  out  16  index of the bank currently being processed
- busy  out  1  high from the first cycle after reset release until done
- done  out  1  sticky; all banks accumulated
- err  out  1  sticky; eng_result_valid received outside WAIT_RESULT

## Operation

- States: IDLE, STREAM, WAIT_RESULT, ACCUM, DONE.
- IDLE: entered on reset. Transitions to STREAM on the first clock edge after rst deasserts.
- STREAM:
  - Issue sequential rom_addr.
  - Feed returned digits through a 2-entry skid buffer so the ROM's 1-cycle latency does not cost throughput.
  - The address counter advances only while the skid buffer has room. No digit is dropped or duplicated under any eng_ready pattern.
  - eng_valid is held, with eng_digit stable, until accepted.
  - After the handshake on the eng_last digit, go to WAIT_RESULT. No digit of the next bank is issued to the engine until then.
- WAIT_RESULT: hold eng_valid=0. On eng_result_valid, latch eng_result and go to ACCUM.
- ACCUM:
  - score <= score + zero-extended result, modulo 2^SCORE_W, no saturation.
  - If bank_idx == NUM_BANKS-1, go to DONE.
  - Otherwise increment bank_idx and return to STREAM.
- DONE: busy=0, done=1. rom_addr holds its last value. Ignores all engine inputs except for err detection.
- err: eng_result_valid in any state other than WAIT_RESULT sets err. The result is discarded and score is unchanged.
- Reset mid-run: all state clears asynchronously. The run restarts from bank 0 after release, with score=0.

## Timing

- Reset values: rom_addr=0, eng_start=0, eng_valid=0, eng_digit=0, eng_last=0, score=0, bank_idx=0, busy=0, done=0, err=0.
- Cycle 1 after rst release: STREAM, busy=1, rom_addr=0.
- Cycle 2 after rst release: eng_valid=1, eng_start=1, digit from address 0.
- With eng_ready tied high: one digit per cycle, BANK_LEN consecutive cycles of eng_valid per bank.
- eng_start asserts only on the first digit's first valid cycle. It does not re-pulse while that digit stalls.
- Result to score: score updates on the edge after the eng_result_valid cycle (visible 1 cycle later).
- Bank turnaround: the first digit of the next bank appears no later than 3 cycles after the ACCUM cycle.
- done rises in the cycle after the final ACCUM.

## Test plan

- NUM_BANKS=2, BANK_LEN=4, ROM "1234","9119", behavioural engine (max ordered digit pair), eng_ready=1 -> results 34 then 99; score 34 then 133; done=1; err=0; exactly 8 digit handshakes.
- Same ROM, eng_ready toggled by a random 50% pattern -> digit sequence at the engine exactly 1,2,3,4,9,1,1,9; eng_start pulses exactly twice; final score=133.
- Engine delays eng_result_valid by 20 cycles after eng_last -> eng_valid stays 0 throughout the wait; score unchanged until the pulse.
- Spurious eng_result_valid with result 55 during STREAM -> err=1, sticky; score unaffected; final score still 133.
- rst asserted for 2 cycles midway through bank 1 -> all outputs return to reset values immediately; rerun yields score=133 and done=1.
- Default parameters with the puzzle input ROM and the real engine -> done within NUM_BANKS*(BANK_LEN+6) cycles; score=16764.

Source files
------------

// File: rtl/bank_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bank_scheduler: streams each bank of the digit ROM into the max-joltage      |
// | engine, collects one result per bank and accumulates the total score.       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module bank_scheduler #(
   parameter int NUM_BANKS = 200,
   parameter int BANK_LEN  = 100,
   parameter int ADDR_W    = 15,
   parameter int RESULT_W  = 8,
   parameter int SCORE_W   = 32
) (
   input  logic                clk,
   input  logic                rst,
   output logic [ADDR_W-1:0]   rom_addr,
   input  logic [3:0]          rom_data,
   output logic                eng_start,
   output logic                eng_valid,
   output logic [3:0]          eng_digit,
   output logic                eng_last,
   input  logic                eng_ready,
   input  logic [RESULT_W-1:0] eng_result,
   input  logic                eng_result_valid,
   output logic [SCORE_W-1:0]  score,
   output logic [15:0]         bank_idx,
   output logic                busy,
   output logic                done,
   output logic                err
);

   localparam int                 CNT_W       = $clog2(BANK_LEN + 1);
   localparam logic [CNT_W-1:0]   LEN_C       = CNT_W'(BANK_LEN);
   localparam logic [CNT_W-1:0]   LAST_C      = CNT_W'(BANK_LEN - 1);
   localparam logic [15:0]        LAST_BANK_C = 16'(NUM_BANKS - 1);
   localparam logic [ADDR_W-1:0]  END_ADDR_C  = ADDR_W'(NUM_BANKS * BANK_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_STREAM = 3'd1,
      S_WAIT   = 3'd2,
      S_ACCUM  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
   logic [CNT_W-1:0]    issued_q, issued_d;
   logic [CNT_W-1:0]    accepted_q, accepted_d;
   logic                pend_q, pend_d;
   logic [1:0][3:0]     skid_q, skid_d;
   logic                rd_ptr_q, rd_ptr_d;
   logic                wr_ptr_q, wr_ptr_d;
   logic [1:0]          cnt_q, cnt_d;
   logic                started_q, started_d;
   logic [SCORE_W-1:0]  score_q, score_d;
   logic [15:0]         bank_idx_q, bank_idx_d;
   logic                err_q, err_d;

   logic                streaming;
   logic [3:0]          head;
   logic                fire;
   logic                push;
   logic                pop;
   logic [2:0]          occ;
   logic                issue;

   // pend_q marks that rom_data carries a digit this cycle; it bypasses the
   // skid buffer when the buffer is empty so the first digit costs no cycle.
   assign streaming = (state_q == S_STREAM);
   assign head      = (cnt_q != 2'd0) ? skid_q[rd_ptr_q] : rom_data;
   assign eng_valid = streaming && ((cnt_q != 2'd0) || pend_q);
   assign eng_digit = eng_valid ? head : 4'd0;
   assign eng_last  = eng_valid && (accepted_q == LAST_C);
   assign eng_start = eng_valid && !started_q;
   assign fire      = eng_valid && eng_ready;
   assign pop       = fire && (cnt_q != 2'd0);
   assign push      = pend_q && !(fire && (cnt_q == 2'd0));

   // Occupancy after this cycle; a new read may only be issued if its data
   // is guaranteed a slot when it returns.
   assign occ   = {1'b0, cnt_q} + {2'b00, pend_q} - {2'b00, fire};
   assign issue = streaming && (issued_q != LEN_C) && (occ <= 3'd1);

   always_comb begin
      state_d    = state_q;
      rom_addr_d = rom_addr_q;
      issued_d   = issued_q;
      accepted_d = accepted_q;
      pend_d     = 1'b0;
      skid_d     = skid_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      cnt_d      = cnt_q;
      started_d  = started_q;
      score_d    = score_q;
      bank_idx_d = bank_idx_q;
      err_d      = err_q | (eng_result_valid && (state_q != S_WAIT));

      case (state_q)
         S_IDLE: state_d = S_STREAM;

         S_STREAM: begin
            pend_d = issue;
            if (issue) begin
               issued_d = issued_q + 1'b1;
               if (rom_addr_q != END_ADDR_C) rom_addr_d = rom_addr_q + 1'b1;
            end
            if (push) begin
               skid_d[wr_ptr_q] = rom_data;
               wr_ptr_d         = ~wr_ptr_q;
            end
            if (pop) rd_ptr_d = ~rd_ptr_q;
            cnt_d = occ[1:0];
            if (eng_valid) started_d = 1'b1;
            if (fire) begin
               accepted_d = accepted_q + 1'b1;
               if (eng_last) state_d = S_WAIT;
            end
         end

         // Score is added on the pulse edge so it is visible one cycle later.
         S_WAIT: begin
            if (eng_result_valid) begin
               score_d = score_q + SCORE_W'(eng_result);
               state_d = S_ACCUM;
            end
         end

         S_ACCUM: begin
            issued_d   = '0;
            accepted_d = '0;
            started_d  = 1'b0;
            if (bank_idx_q == LAST_BANK_C) begin
               state_d = S_DONE;
            end else begin
               bank_idx_d = bank_idx_q + 16'd1;
               state_d    = S_STREAM;
            end
         end

         S_DONE: state_d = S_DONE;

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         rom_addr_q <= '0;
         issued_q   <= '0;
         accepted_q <= '0;
         pend_q     <= 1'b0;
         skid_q     <= '0;
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         cnt_q      <= 2'd0;
         started_q  <= 1'b0;
         score_q    <= '0;
         bank_idx_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rom_addr_q <= rom_addr_d;
         issued_q   <= issued_d;
         accepted_q <= accepted_d;
         pend_q     <= pend_d;
         skid_q     <= skid_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         cnt_q      <= cnt_d;
         started_q  <= started_d;
         score_q    <= score_d;
         bank_idx_q <= bank_idx_d;
         err_q      <= err_d;
      end
   end

   assign rom_addr = rom_addr_q;
   assign score    = score_q;
   assign bank_idx = bank_idx_q;
   assign busy     = (state_q == S_STREAM) || (state_q == S_WAIT) || (state_q == S_ACCUM);
   assign done     = (state_q == S_DONE);
   assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bank_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bank_scheduler: scoreboard bench with ROM model and behavioural engine.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_bank_scheduler;

   localparam int NB = 2;
   localparam int BL = 4;
   localparam int AW = 3;
   localparam int RW = 8;
   localparam int SW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] rom_addr;
   logic [3:0]    rom_data = 4'd0;
   logic          eng_start, eng_valid, eng_last;
   logic [3:0]    eng_digit;
   logic          eng_ready = 1'b0;
   logic [RW-1:0] eng_result = '0;
   logic          eng_result_valid = 1'b0;
   logic [SW-1:0] score;
   logic [15:0]   bank_idx;
   logic          busy, done, err;

   always #5 clk = ~clk;

   bank_scheduler #(
      .NUM_BANKS(NB), .BANK_LEN(BL), .ADDR_W(AW), .RESULT_W(RW), .SCORE_W(SW)
   ) dut (
      .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
      .eng_start(eng_start), .eng_valid(eng_valid), .eng_digit(eng_digit),
      .eng_last(eng_last), .eng_ready(eng_ready), .eng_result(eng_result),
      .eng_result_valid(eng_result_valid), .score(score), .bank_idx(bank_idx),
      .busy(busy), .done(done), .err(err)
   );

   // Synchronous ROM
   logic [3:0] rom [0:NB*BL-1];
   always @(posedge clk) rom_data <= rom[rom_addr];

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic int maxpair(input logic [3:0] d[$]);
      int m = 0;
      for (int i = 0; i < d.size(); i++)
         for (int j = i + 1; j < d.size(); j++)
            if (10 * int'(d[i]) + int'(d[j]) > m) m = 10 * int'(d[i]) + int'(d[j]);
      return m;
   endfunction

   typedef struct {
      logic [3:0] d;
      bit         first;
      bit         last;
   } dig_t;

   dig_t   dig_q[$];
   longint score_q[$];
   longint exp_total;
   int     hs_cnt = 0;
   int     start_cnt = 0;

   task automatic load_expect();
      logic [3:0] bank[$];
      longint s = 0;
      dig_q.delete();
      score_q.delete();
      for (int b = 0; b < NB; b++) begin
         bank.delete();
         for (int i = 0; i < BL; i++) begin
            dig_q.push_back('{d: rom[b*BL+i], first: (i == 0), last: (i == BL-1)});
            bank.push_back(rom[b*BL+i]);
         end
         s = (s + maxpair(bank)) % (64'd1 << SW);
         score_q.push_back(s);
      end
      exp_total = s;
      hs_cnt    = 0;
      start_cnt = 0;
   endtask

   // Behavioural engine
   int         delay_cfg = 0;
   bit         rnd_ready = 1'b0;
   int         spur_mode = 0;
   logic [3:0] ebuf[$];
   bit         res_pend = 1'b0;
   int         cd = 0;

   initial begin
      bit spur_now;
      forever begin
         @(negedge clk);
         if (rst) begin
            ebuf.delete();
            res_pend = 1'b0;
         end else if (eng_valid && eng_ready) begin
            ebuf.push_back(eng_digit);
            if (eng_last) begin
               res_pend = 1'b1;
               cd       = delay_cfg;
            end
         end
         spur_now = !rst && ((spur_mode == 1 && eng_valid && !res_pend) || spur_mode == 2);
         @(posedge clk);
         #1;
         eng_result_valid = 1'b0;
         eng_result       = '0;
         eng_ready        = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (spur_now) begin
            eng_result_valid = 1'b1;
            eng_result       = 8'd55;
            spur_mode        = 0;
         end else if (res_pend) begin
            if (cd == 0) begin
               eng_result_valid = 1'b1;
               eng_result       = RW'(maxpair(ebuf));
               ebuf.delete();
               res_pend = 1'b0;
            end else begin
               cd--;
            end
         end
      end
   end

   // Monitor
   initial begin
      bit     stalled = 1'b0;
      bit     waiting = 1'b0;
      longint last_score = 0;
      dig_t   e;
      forever begin
         @(negedge clk);
         if (rst) begin
            stalled    = 1'b0;
            waiting    = 1'b0;
            last_score = 0;
         end else begin
            if (eng_result_valid) waiting = 1'b0;
            if (eng_start) start_cnt++;
            if (eng_valid) begin
               if (waiting) chk("valid_during_wait", 1, 0);
               if (dig_q.size() == 0) begin
                  chk("unexpected_digit", 1, 0);
               end else begin
                  chk("start", eng_start, dig_q[0].first && !stalled);
                  if (eng_ready) begin
                     e = dig_q.pop_front();
                     chk("digit", eng_digit, e.d);
                     chk("last", eng_last, e.last);
                     hs_cnt++;
                     if (e.last) waiting = 1'b1;
                  end
               end
               stalled = !eng_ready;
            end else begin
               if (eng_start) chk("start_without_valid", 1, 0);
               stalled = 1'b0;
            end
            if (score != last_score) begin
               if (score_q.size() == 0) chk("unexpected_score_change", score, last_score);
               else chk("score", score, score_q.pop_front());
               last_score = score;
            end
         end
      end
   end

   task automatic check_reset_vals(input string tag);
      chk({tag, "_reset_outputs"},
          {rom_addr, eng_start, eng_valid, eng_digit, eng_last, bank_idx, busy, done, err}, 0);
      chk({tag, "_reset_score"}, score, 0);
   endtask

   task automatic run_case(input string tag, input int dly, input bit rr, input bit spur,
                           input bit abort, input bit late_spur);
      int n;
      delay_cfg = dly;
      rnd_ready = rr;
      @(posedge clk);
      #1 rst = 1'b1;
      #1 check_reset_vals(tag);
      load_expect();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      spur_mode = spur ? 1 : 0;
      @(posedge clk);
      #1;
      chk({tag, "_c1_busy"}, busy, 1);
      chk({tag, "_c1_addr"}, rom_addr, 0);
      chk({tag, "_c1_valid"}, eng_valid, 0);
      @(posedge clk);
      #1;
      chk({tag, "_c2_valid_start"}, {eng_valid, eng_start}, 2'b11);
      chk({tag, "_c2_digit"}, eng_digit, rom[0]);
      n = 2;
      if (abort) begin
         int w = 0;
         while (hs_cnt < BL + 2 && w < 200) begin
            @(posedge clk);
            w++;
         end
         chk({tag, "_abort_reach_timeout"}, hs_cnt >= BL + 2, 1);
         #1 rst = 1'b1;
         #1 check_reset_vals({tag, "_mid"});
         repeat (2) @(posedge clk);
         #1 load_expect();
         rst = 1'b0;
         n = 0;
      end
      while (!done && n < 600) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk({tag, "_done_timeout"}, done, 1);
      if (!rr) chk({tag, "_latency"}, n <= NB * (BL + 6) + NB * dly, 1);
      repeat (4) @(posedge clk);
      #1;
      chk({tag, "_final_score"}, score, exp_total);
      chk({tag, "_final_flags"}, {done, busy, err}, {1'b1, 1'b0, spur});
      chk({tag, "_final_addr"}, rom_addr, NB * BL - 1);
      chk({tag, "_handshakes"}, hs_cnt, NB * BL);
      chk({tag, "_starts"}, start_cnt, NB);
      chk({tag, "_queues_drained"}, dig_q.size() + score_q.size(), 0);
      if (late_spur) begin
         spur_mode = 2;
         repeat (4) @(posedge clk);
         #1;
         chk({tag, "_late_err"}, {err, done}, 2'b11);
         chk({tag, "_late_score"}, score, exp_total);
      end
   endtask

   initial begin
      logic [3:0] fixed_rom [0:NB*BL-1] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd1, 4'd1, 4'd9};
      for (int i = 0; i < NB * BL; i++) rom[i] = fixed_rom[i];
      run_case("basic", 0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("basic_total_133", exp_total, 133);
      run_case("rnd_ready", 0, 1'b1, 1'b0, 1'b0, 1'b0);
      run_case("slow_engine", 20, 1'b0, 1'b0, 1'b0, 1'b0);
      run_case("spurious", 0, 1'b0, 1'b1, 1'b0, 1'b0);
      run_case("abort", 0, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < NB * BL; i++) rom[i] = 4'($urandom_range(1, 9));
         run_case($sformatf("random%0d", r), $urandom_range(0, 5), 1'b1, 1'b0, 1'b0, r == 3);
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
